// File: rtl/block_fetch_buffer.sv
// block_fetch_buffer
// Fetches one BLK_DIM x BLK_DIM block from a synchronous single-port memory
// into a shadow buffer, then hands it to the registered output array under
// a valid/ready handshake. The shadow lets the next block be fetched while
// the consumer still holds the current one. Optional transpose on load.

module block_fetch_buffer #(
    parameter int DATA_W        = 32,
    parameter int BLK_DIM       = 8,
    parameter int MAX_BLOCK_NUM = 32,
    parameter int ADDR_W        = 12
) (
    input  logic                                         clock,
    input  logic                                         reset_n,
    input  logic                                         start,
    output logic                                         start_ready,
    input  logic [ADDR_W-1:0]                            offset,
    input  logic [31:0]                                  block_index,
    input  logic                                         transpose,
    output logic                                         mem_rd_en,
    output logic [ADDR_W-1:0]                            mem_addr,
    input  logic [DATA_W-1:0]                            mem_rd_data,
    output logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_W-1:0]  output_data_array,
    output logic                                         out_valid,
    input  logic                                         out_ready
);

    // Row/column counters need at least one bit even for a 1x1 block.
    localparam int                CNT_W     = (BLK_DIM > 1) ? $clog2(BLK_DIM) : 1;
    localparam logic [CNT_W-1:0]  LAST_IDX  = CNT_W'(BLK_DIM - 1);
    // MAX_BLOCK_NUM is a power of two, so the modulo reduces to a mask.
    localparam logic [31:0]       IDX_MASK  = 32'(MAX_BLOCK_NUM - 1);
    localparam logic [ADDR_W-1:0] BLK_WORDS = ADDR_W'(BLK_DIM * BLK_DIM);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t                                       state_r;
    logic [CNT_W-1:0]                             row_cnt_r;
    logic [CNT_W-1:0]                             col_cnt_r;
    logic                                         xpose_r;
    logic                                         rd_pend_r;
    logic [CNT_W-1:0]                             wr_row_r;
    logic [CNT_W-1:0]                             wr_col_r;
    logic [BLK_DIM-1:0][BLK_DIM-1:0][DATA_W-1:0]  shadow_r;
    logic [ADDR_W-1:0]                            base_s;
    logic                                         copy_s;
    logic                                         last_issue_s;

    // Block base address and shadow-to-output copy decision.
    always_comb begin
        base_s       = offset + (ADDR_W'(block_index & IDX_MASK) * BLK_WORDS);
        last_issue_s = (row_cnt_r == LAST_IDX) && (col_cnt_r == LAST_IDX);
        copy_s       = 1'b0;
        if (state_r == DRAIN) begin
            // Drain is complete once no read is still returning data.
            copy_s = !rd_pend_r && (!out_valid || out_ready);
        end else if (state_r == WAIT) begin
            copy_s = out_ready;
        end else begin
            copy_s = 1'b0;
        end
    end

    // Control FSM: accepts requests, issues one read per cycle, waits for the output slot.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            start_ready <= 1'b1;
            mem_rd_en   <= 1'b0;
            mem_addr    <= {ADDR_W{1'b0}};
            row_cnt_r   <= {CNT_W{1'b0}};
            col_cnt_r   <= {CNT_W{1'b0}};
            xpose_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= FETCH;
                        start_ready <= 1'b0;
                        mem_rd_en   <= 1'b1;
                        mem_addr    <= base_s;
                        row_cnt_r   <= {CNT_W{1'b0}};
                        col_cnt_r   <= {CNT_W{1'b0}};
                        xpose_r     <= transpose;
                    end else begin
                        start_ready <= 1'b1;
                        mem_rd_en   <= 1'b0;
                    end
                end
                FETCH: begin
                    if (last_issue_s) begin
                        state_r   <= DRAIN;
                        mem_rd_en <= 1'b0;
                    end else begin
                        mem_rd_en <= 1'b1;
                        mem_addr  <= mem_addr + ADDR_W'(1);
                        if (col_cnt_r == LAST_IDX) begin
                            col_cnt_r <= {CNT_W{1'b0}};
                            row_cnt_r <= row_cnt_r + CNT_W'(1);
                        end else begin
                            col_cnt_r <= col_cnt_r + CNT_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    mem_rd_en <= 1'b0;
                    if (copy_s) begin
                        state_r     <= IDLE;
                        start_ready <= 1'b1;
                    end else if (!rd_pend_r) begin
                        // Shadow is complete but the output still holds an unconsumed block.
                        state_r <= WAIT;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                WAIT: begin
                    mem_rd_en <= 1'b0;
                    if (copy_s) begin
                        state_r     <= IDLE;
                        start_ready <= 1'b1;
                    end else begin
                        state_r <= WAIT;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    start_ready <= 1'b1;
                    mem_rd_en   <= 1'b0;
                end
            endcase
        end
    end

    // Read-return pipeline: remember which element each read targets and write the shadow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_pend_r <= 1'b0;
            wr_row_r  <= {CNT_W{1'b0}};
            wr_col_r  <= {CNT_W{1'b0}};
            for (int r = 0; r < BLK_DIM; r++) begin
                for (int c = 0; c < BLK_DIM; c++) begin
                    shadow_r[r][c] <= DATA_W'(1);
                end
            end
        end else begin
            rd_pend_r <= mem_rd_en;
            wr_row_r  <= row_cnt_r;
            wr_col_r  <= col_cnt_r;
            if (rd_pend_r) begin
                if (xpose_r) begin
                    shadow_r[wr_col_r][wr_row_r] <= mem_rd_data;
                end else begin
                    shadow_r[wr_row_r][wr_col_r] <= mem_rd_data;
                end
            end
        end
    end

    // Output slot: load from the shadow on a copy edge, clear valid on a plain handoff.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            for (int r = 0; r < BLK_DIM; r++) begin
                for (int c = 0; c < BLK_DIM; c++) begin
                    output_data_array[r][c] <= DATA_W'(1);
                end
            end
        end else begin
            if (copy_s) begin
                output_data_array <= shadow_r;
                out_valid         <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_block_fetch_buffer.sv
// Directed bench for block_fetch_buffer: memory word[a] = a, hand-computed expectations.
module tb_block_fetch_buffer;

    localparam int DW = 32;
    localparam int BD = 8;
    localparam int AW = 12;

    logic                         clock;
    logic                         reset_n;
    logic                         start;
    logic                         start_ready;
    logic [AW-1:0]                offset;
    logic [31:0]                  block_index;
    logic                         transpose;
    logic                         mem_rd_en;
    logic [AW-1:0]                mem_addr;
    logic [DW-1:0]                mem_rd_data;
    logic [BD-1:0][BD-1:0][DW-1:0] arr;
    logic                         out_valid;
    logic                         out_ready;

    int n_checks = 0;
    int n_fail   = 0;

    block_fetch_buffer #(
        .DATA_W(DW), .BLK_DIM(BD), .MAX_BLOCK_NUM(32), .ADDR_W(AW)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .start(start),
        .start_ready(start_ready),
        .offset(offset),
        .block_index(block_index),
        .transpose(transpose),
        .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr),
        .mem_rd_data(mem_rd_data),
        .output_data_array(arr),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous memory model: word[a] = a, one cycle read latency.
    always @(posedge clock) begin
        if (mem_rd_en) mem_rd_data <= DW'(mem_addr);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Count array elements differing from word (base + 8r + c), optionally transposed.
    task automatic check_block(input string tag, input logic [AW-1:0] base, input logic tr);
        int errs = 0;
        logic [AW-1:0] a;
        logic [DW-1:0] got;
        for (int r = 0; r < BD; r++) begin
            for (int c = 0; c < BD; c++) begin
                a   = base + AW'(BD * r + c);
                got = tr ? arr[c][r] : arr[r][c];
                if (got !== DW'(a)) errs++;
            end
        end
        check_eq(tag, errs, 0);
    endtask

    task automatic check_all_ones(input string tag);
        int errs = 0;
        for (int r = 0; r < BD; r++) begin
            for (int c = 0; c < BD; c++) begin
                if (arr[r][c] !== DW'(1)) errs++;
            end
        end
        check_eq(tag, errs, 0);
    endtask

    // Issue a request and check the 64 read strobes/addresses; returns at sample T0+64.
    task automatic fetch_reads(input logic [AW-1:0] off, input logic [31:0] idx,
                               input logic tr, input logic [AW-1:0] base);
        logic [AW-1:0] a;
        offset      = off;
        block_index = idx;
        transpose   = tr;
        start       = 1'b1;
        tick();
        start = 1'b0;
        check_eq("busy_after_accept", start_ready, 0);
        for (int n = 0; n < BD * BD; n++) begin
            a = base + AW'(n);
            check_eq("rd_en", mem_rd_en, 1);
            check_eq("rd_addr", mem_addr, a);
            tick();
        end
        check_eq("rd_en_off_in_drain", mem_rd_en, 0);
    endtask

    // Continue from sample T0+64 until out_valid rises; expect it after edge T0+66.
    task automatic wait_valid();
        int n = BD * BD;
        while (!out_valid && n < 200) begin
            tick();
            n++;
        end
        check_eq("valid_latency", n, BD * BD + 2);
        check_eq("ready_after_copy", start_ready, 1);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("valid_cleared", out_valid, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        offset      = '0;
        block_index = '0;
        transpose   = 1'b0;
        out_ready   = 1'b0;
        #23;
        // Reset state
        check_all_ones("reset_array");
        check_eq("reset_valid", out_valid, 0);
        check_eq("reset_ready", start_ready, 1);
        check_eq("reset_rd_en", mem_rd_en, 0);
        check_eq("reset_addr", mem_addr, 0);
        reset_n = 1'b1;
        tick();
        tick();
        check_all_ones("release_array");
        check_eq("release_valid", out_valid, 0);
        check_eq("release_ready", start_ready, 1);
        check_eq("release_rd_en", mem_rd_en, 0);

        // Block 3, no transpose: addresses 192..255
        fetch_reads(12'd0, 32'd3, 1'b0, 12'd192);
        wait_valid();
        check_block("blk3_data", 12'd192, 1'b0);
        check_eq("blk3_first", arr[0][0], 192);
        check_eq("blk3_last", arr[7][7], 255);
        consume();

        // Wrap: offset 4000, index 33 -> base 4064
        fetch_reads(12'd4000, 32'd33, 1'b0, 12'd4064);
        wait_valid();
        check_block("wrap_data", 12'd4064, 1'b0);
        check_eq("wrap_77", arr[7][7], 31);
        check_eq("wrap_00", arr[0][0], 4064);
        consume();

        // Transpose, block 0
        fetch_reads(12'd0, 32'd0, 1'b1, 12'd0);
        wait_valid();
        check_block("xpose_data", 12'd0, 1'b1);
        check_eq("xpose_01", arr[0][1], 8);
        check_eq("xpose_10", arr[1][0], 1);
        consume();

        // Back-to-back with a stalled consumer
        fetch_reads(12'd0, 32'd0, 1'b0, 12'd0);
        wait_valid();
        check_block("b2b_blk0", 12'd0, 1'b0);
        fetch_reads(12'd0, 32'd1, 1'b0, 12'd64);
        repeat (8) tick();
        check_eq("wait_ready_low", start_ready, 0);
        check_eq("wait_valid_high", out_valid, 1);
        check_block("wait_holds_blk0", 12'd0, 1'b0);
        start       = 1'b1;
        block_index = 32'd7;
        tick();
        start = 1'b0;
        check_eq("wait_start_ignored", mem_rd_en, 0);
        check_eq("wait_still_busy", start_ready, 0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_eq("b2b_valid_kept", out_valid, 1);
        check_block("b2b_blk1", 12'd64, 1'b0);
        check_eq("b2b_ready_back", start_ready, 1);
        tick();
        check_eq("b2b_no_new_fetch", mem_rd_en, 0);
        consume();

        // Reset during a fetch at read 20
        offset      = 12'd0;
        block_index = 32'd2;
        transpose   = 1'b0;
        start       = 1'b1;
        tick();
        start = 1'b0;
        repeat (20) tick();
        check_eq("pre_reset_addr", mem_addr, 148);
        reset_n = 1'b0;
        #1;
        check_eq("mid_reset_rd_en", mem_rd_en, 0);
        check_eq("mid_reset_ready", start_ready, 1);
        check_eq("mid_reset_valid", out_valid, 0);
        tick();
        reset_n = 1'b1;
        repeat (80) begin
            tick();
            if (mem_rd_en || out_valid) break;
        end
        check_eq("post_reset_no_rd", mem_rd_en, 0);
        check_eq("post_reset_no_valid", out_valid, 0);
        check_all_ones("post_reset_array");
        fetch_reads(12'd0, 32'd5, 1'b0, 12'd320);
        wait_valid();
        check_block("post_reset_data", 12'd320, 1'b0);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/block_fetch_buffer.md
# block_fetch_buffer

Parametrised block fetcher that reads one BLK_DIM×BLK_DIM block of pixels from a synchronous single-port memory and presents it as a registered 2-D array to the DCT/quantiser stages. It replaces direct whole-memory indexing with a sequential read port and a valid/ready output handshake. It adds optional transpose on load and a shadow buffer, so the next block is fetched while the current one is still held.

## Interface
Parameters:
- DATA_W, 32: pixel/word width.
- BLK_DIM, 8: block edge; a block is BLK_DIM² words.
- MAX_BLOCK_NUM, 32: blocks per slice; power of two.
- ADDR_W, 12: memory address width (4096 words).

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset (0 = reset, 1 = run).
- start  in  1  request a block fetch.
- start_ready  out  1  fetch request accepted when start && start_ready at a clock edge.
- offset  in  ADDR_W  slice base address, sampled on accept.
- block_index  in  32  block number, sampled on accept; used modulo MAX_BLOCK_NUM.
- transpose  in  1  sampled on accept; 1 = store word (r,c) at array[c][r].
- mem_rd_en  out  1  memory read strobe.
- mem_addr  out  ADDR_W  memory read address.
- mem_rd_data  in  DATA_W  read data, valid in the cycle after the mem_rd_en cycle.
- output_data_array  out  DATA_W × [BLK_DIM][BLK_DIM]  registered block.
- out_valid  out  1  output_data_array holds an unconsumed block.
- out_ready  in  1  consumer takes the block when out_valid && out_ready.

## Operation
- States: IDLE (shadow free), FETCH (issuing reads), DRAIN (collecting trailing read data), WAIT (shadow full, output occupied).
- start_ready = (state == IDLE), including while out_valid is still high from the previous block.
- On accept, latch base = offset + (block_index mod MAX_BLOCK_NUM)·BLK_DIM², computed in ADDR_W bits with wrap modulo 2^ADDR_W. Latch transpose. Go to FETCH.
- FETCH: for k = 0 … BLK_DIM²−1, one read per cycle with mem_rd_en = 1 and mem_addr = base + k (wraps modulo 2^ADDR_W). After the last issue, go to DRAIN.
- Each returning word k is written to shadow[k / BLK_DIM][k % BLK_DIM], or to the swapped indices if transpose is set.
- DRAIN ends when the last word has been written. The next step depends on the output:
  - If out_valid = 0, or out_valid && out_ready, at that edge: copy the shadow to output_data_array, set out_valid = 1, go to IDLE.
  - Otherwise go to WAIT.
- WAIT: at the first edge with out_ready = 1, copy the shadow, keep out_valid = 1, go to IDLE.
- Consumer handshake with no pending copy clears out_valid. A copy and a handshake at the same edge leave out_valid = 1 with the new data.
- output_data_array changes only on a copy edge; it is stable while out_valid is high and not handed off.
- start is ignored outside IDLE. No error flag.

## Timing
- Reset values (asynchronous, immediate):
  - Every output_data_array element = 1.
  - out_valid = 0.
  - mem_rd_en = 0, mem_addr = 0.
  - State IDLE, so start_ready = 1.
- Accept edge T0: mem_rd_en is high for the BLK_DIM² cycles following T0, one address per cycle.
- The last data is captured at edge T0 + BLK_DIM² + 1. With the output free, out_valid rises after edge T0 + BLK_DIM² + 2 (66 clocks for BLK_DIM = 8).
- start_ready returns high in the cycle after the copy edge. Back-to-back throughput is one block per BLK_DIM² + 3 clocks when the consumer never stalls.
- mem_rd_en is never high in DRAIN, WAIT or IDLE.
- reset_n low mid-FETCH: mem_rd_en drops immediately. The in-flight block is discarded and no late mem_rd_data is written after release.

## Test plan
- Reset, then release: all array elements = 1, out_valid = 0, start_ready = 1, mem_rd_en = 0.
- Memory word[a] = a. Fetch with offset = 0, block_index = 3, transpose = 0:
  - addresses 192…255 are issued on consecutive cycles;
  - out_valid rises 66 clocks after accept;
  - array[r][c] = 192 + 8r + c.
- Wrap: offset = 4000, block_index = 33 (treated as 1), so base = 4064:
  - mem_addr runs 4064…4095 then 0…31;
  - array[7][7] = 31.
- Transpose = 1, block_index = 0: array[c][r] = 8r + c, so array[0][1] = 8.
- Back-to-back with out_ready = 0: block 0 is delivered and block 1 is fetched into the shadow, then the block waits in WAIT. array stays at block 0 and start_ready = 0. Raising out_ready for one cycle loads block 1 and keeps out_valid = 1.
- Assert reset_n = 0 at read 20 of a fetch: mem_rd_en = 0 immediately. After release, the next start fetches cleanly and the array has no stale words.
